// File: rtl/aes_inv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_pkg
//  Purpose  : Shared types, round constants and GF(2^8) helpers for the
//             AES-128 inverse cipher core. S-boxes are computed as the field
//             inverse followed by the (inverse) affine transform.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_inv_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } aes_state_e;

  // Key-schedule round constants, indexed by expansion step 0..9
  localparam logic [7:0] c_rcon [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // a^254 == a^-1 in GF(2^8); also maps 0 to 0
  localparam logic [7:0] c_inv_exp = 8'hfe;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse by square-and-multiply exponentiation to 254
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (c_inv_exp[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse then affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform then field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_core_round.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_round
//  Purpose  : Combinational AES inverse round: InvShiftRows, InvSubBytes,
//             AddRoundKey, then InvMixColumns unless i_last is set.
//             Byte n of a block is bits [127-8n -: 8], row = n%4, col = n/4.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [7:0] w_sr  [0:15];
  logic [7:0] w_sb  [0:15];
  logic [7:0] w_ark [0:15];
  logic [7:0] w_mix [0:15];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int c_src = r + 4 * c;
      // Row r rotates right by r columns
      localparam int c_dst = r + 4 * ((c + r) % 4);

      assign w_sr[c_dst]  = i_state[127 - 8 * c_src -: 8];
      assign w_sb[c_src]  = inv_sbox(w_sr[c_src]);
      assign w_ark[c_src] = w_sb[c_src] ^ i_rkey[127 - 8 * c_src -: 8];
      assign w_mix[c_src] = gf_mul(8'h0e, w_ark[r + 4 * c])
                          ^ gf_mul(8'h0b, w_ark[((r + 1) % 4) + 4 * c])
                          ^ gf_mul(8'h0d, w_ark[((r + 2) % 4) + 4 * c])
                          ^ gf_mul(8'h09, w_ark[((r + 3) % 4) + 4 * c]);
      assign o_state[127 - 8 * c_src -: 8] = i_last ? w_ark[c_src] : w_mix[c_src];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_cipher_core
//  Purpose  : Iterative AES-128 inverse cipher. Expands a loaded key into 11
//             stored round keys (one per clock), then decrypts one block per
//             11 cycles using a single shared inverse-round datapath.
//  Options  : AES_INV_BUSY_OUT_EN - adds output 'busy' (high in KEXP/DEC).
//  Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_core
  import aes_inv_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         key_ready,
  output logic         done,
  output logic [127:0] text_out
`ifdef AES_INV_BUSY_OUT_EN
  ,
  output logic         busy
`endif
);

  aes_state_e   r_state;
  aes_state_e   w_next_state;

  logic [127:0] r_rk [0:NR];
  logic [127:0] r_klast;
  logic [3:0]   r_kidx;
  logic         r_key_ready;

  logic [127:0] r_data;
  logic [3:0]   r_round;
  logic [127:0] r_text_out;
  logic         r_done;

  logic         w_ld_accept;
  logic         w_kexp_step;
  logic         w_kexp_last;
  logic         w_dec_step;
  logic         w_dec_last;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_kt;
  logic [31:0]  w_nw0, w_nw1, w_nw2, w_nw3;
  logic [127:0] w_next_rk;
  logic [127:0] w_round_key;
  logic [127:0] w_round_out;
  logic         w_last;

  // ---------------------------------------------------------------------
  // Key schedule step: next 4 words from the most recently produced key
  // ---------------------------------------------------------------------
  assign w_rot = {r_klast[23:0], r_klast[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    assign w_sub[8 * b +: 8] = sbox(w_rot[8 * b +: 8]);
  end

  // r_kidx stays within 0..NR-1, so it always addresses a valid constant
  assign w_kt  = w_sub ^ {c_rcon[r_kidx], 24'h000000};
  assign w_nw0 = r_klast[127:96] ^ w_kt;
  assign w_nw1 = r_klast[95:64]  ^ w_nw0;
  assign w_nw2 = r_klast[63:32]  ^ w_nw1;
  assign w_nw3 = r_klast[31:0]   ^ w_nw2;
  assign w_next_rk = {w_nw0, w_nw1, w_nw2, w_nw3};

  // ---------------------------------------------------------------------
  // Shared inverse round
  // ---------------------------------------------------------------------
  assign w_round_key = r_rk[r_round];
  assign w_last      = (r_round == 4'd0);

  aes_inv_round u_round (
    .i_state (r_data),
    .i_rkey  (w_round_key),
    .i_last  (w_last),
    .o_state (w_round_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and step enables; kld overrides everything else
  always_comb begin
    w_next_state = r_state;
    w_ld_accept  = 1'b0;
    w_kexp_step  = 1'b0;
    w_kexp_last  = 1'b0;
    w_dec_step   = 1'b0;
    w_dec_last   = 1'b0;
    if (kld) begin
      w_next_state = KEXP;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld && r_key_ready) begin
            w_ld_accept  = 1'b1;
            w_next_state = DEC;
          end
        end
        KEXP: begin
          w_kexp_step = 1'b1;
          if (r_kidx == 4'(NR - 1)) begin
            w_kexp_last  = 1'b1;
            w_next_state = IDLE;
          end
        end
        DEC: begin
          w_dec_step = 1'b1;
          if (w_last) begin
            w_dec_last   = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Round-key store and key-ready flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      r_klast     <= '0;
      r_kidx      <= '0;
      r_key_ready <= 1'b0;
    end else if (kld) begin
      r_rk[0]     <= key;
      r_klast     <= key;
      r_kidx      <= '0;
      r_key_ready <= 1'b0;
    end else if (w_kexp_step) begin
      r_rk[r_kidx + 4'd1] <= w_next_rk;
      r_klast             <= w_next_rk;
      if (w_kexp_last) begin
        r_kidx      <= '0;
        r_key_ready <= 1'b1;
      end else begin
        r_kidx <= r_kidx + 4'd1;
      end
    end
  end

  // Decryption datapath, round counter and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data     <= '0;
      r_round    <= '0;
      r_text_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ld_accept) begin
        r_data  <= text_in ^ r_rk[NR];
        r_round <= 4'(NR - 1);
      end else if (w_dec_step) begin
        r_data <= w_round_out;
        if (w_dec_last) begin
          // Counter parks at 0 so the key mux never leaves the store
          r_text_out <= w_round_out;
          r_done     <= 1'b1;
        end else begin
          r_round <= r_round - 4'd1;
        end
      end
    end
  end

  assign key_ready = r_key_ready;
  assign done      = r_done;
  assign text_out  = r_text_out;

`ifdef AES_INV_BUSY_OUT_EN
  assign busy = (r_state != IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_inv_cipher_core
//  Purpose  : Self-checking bench for aes_inv_cipher_core. A byte-level AES
//             reference (table S-box, FIPS-197 cipher/inverse cipher) plus a
//             latency model predicts every output each cycle; FIPS-197 vectors
//             pin both the model and the DUT.
//  Options  : AES_INV_BUSY_OUT_EN - also checks 'busy'.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_core;

  logic         clk;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic         ld;
  logic [127:0] text_in;
  logic         key_ready;
  logic         done;
  logic [127:0] text_out;
`ifdef AES_INV_BUSY_OUT_EN
  logic         busy;
`endif

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .kld       (kld),
    .key       (key),
    .ld        (ld),
    .text_in   (text_in),
    .key_ready (key_ready),
    .done      (done),
    .text_out  (text_out)
`ifdef AES_INV_BUSY_OUT_EN
    ,
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------- AES reference -----------------------------
  logic [7:0] m_sb  [256];
  logic [7:0] m_isb [256];

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      m_sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    m_sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) m_isb[m_sb[i]] = 8'(i);
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++)
      y[127-8*i -: 8] = inv ? m_isb[x[127-8*i -: 8]] : m_sb[x[127-8*i -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        else      y[127-8*(r+4*((c+r)%4)) -: 8] = x[127-8*(r+4*c) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0] k [4];
    logic [7:0] acc;
    if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ m_mul(k[j], x[127-8*(((r+j)%4)+4*c) -: 8]);
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] m_roundkey(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sb[t[31:24]], m_sb[t[23:16]], m_sb[t[15:8]], m_sb[t[7:0]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ m_roundkey(k, 0);
    for (int r = 1; r <= 10; r++) begin
      s = m_shift(m_sub(s, 1'b0), 1'b0);
      if (r < 10) s = m_mix(s, 1'b0);
      s = s ^ m_roundkey(k, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ m_roundkey(k, 10);
    for (int r = 9; r >= 0; r--) begin
      s = m_sub(m_shift(s, 1'b1), 1'b1) ^ m_roundkey(k, r);
      if (r > 0) s = m_mix(s, 1'b1);
    end
    return s;
  endfunction

  // ------------------------- cycle/latency model --------------------------
  logic         m_kr = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_out = '0;
  logic [127:0] m_key = '0;
  logic [127:0] m_pend = '0;
  int           m_kcnt = 0;
  int           m_dcnt = 0;

  // Advance the reference model on each active edge from the sampled inputs
  always @(posedge clk) begin
    if (!rst) begin
      m_kr = 1'b0; m_done = 1'b0; m_out = '0; m_kcnt = 0; m_dcnt = 0;
    end else begin
      m_done = 1'b0;
      if (kld) begin
        m_key = key; m_kr = 1'b0; m_kcnt = 10; m_dcnt = 0;
      end else if (m_kcnt == 0 && m_dcnt == 0) begin
        if (ld && m_kr) begin
          m_pend = m_decrypt(m_key, text_in);
          m_dcnt = 10;
        end
      end else if (m_kcnt > 0) begin
        m_kcnt--;
        if (m_kcnt == 0) m_kr = 1'b1;
      end else begin
        m_dcnt--;
        if (m_dcnt == 0) begin m_done = 1'b1; m_out = m_pend; end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", 128'(done), 128'(m_done));
      chk("key_ready", 128'(key_ready), 128'(m_kr));
      chk("text_out", text_out, m_out);
`ifdef AES_INV_BUSY_OUT_EN
      chk("busy", 128'(busy), 128'(m_kcnt > 0 || m_dcnt > 0));
`endif
    end
    if (done === 1'b1) done_cnt++;
  end

  // ------------------------------ stimulus --------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_key(input string name, input int n0);
    int n;
    n = n0;
    while (key_ready !== 1'b1 && n < 40) begin tick(); n++; end
    chk(name, 128'(n), 128'(11));
  endtask

  task automatic wait_done(input string name, input int n0, input logic [127:0] exp);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    chk({name, "_lat"}, 128'(n), 128'(11));
    chk({name, "_data"}, text_out, exp);
  endtask

  task automatic do_kld(input logic [127:0] k, input string name);
    kld = 1'b1; key = k;
    tick();
    kld = 1'b0;
    wait_key(name, 1);
  endtask

  task automatic run_dec(input logic [127:0] ct, input logic [127:0] exp, input string name);
    ld = 1'b1; text_in = ct;
    tick();
    ld = 1'b0;
    wait_done(name, 1, exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int d0;
    logic [127:0] rk, rp, rc;
    build_sbox();
    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;

    // Reference pins
    chk("model_sbox53", 128'(m_sb[8'h53]), 128'(8'hed));
    chk("model_dec_c1", m_decrypt(K_C1, CT_C1), PT_C1);
    chk("model_enc_c1", m_encrypt(K_C1, PT_C1), CT_C1);
    chk("model_dec_b", m_decrypt(K_B, CT_B), PT_B);

    // Reset state
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_text_out", text_out, 128'h0);
    rst = 1'b1;
    tick();

    // FIPS-197 C.1
    do_kld(K_C1, "c1_key_lat");
    run_dec(CT_C1, PT_C1, "c1");

    // FIPS-197 App. B, key reused for a back-to-back second block
    do_kld(K_B, "b_key_lat");
    run_dec(CT_B, PT_B, "b_first");
    run_dec(CT_B, PT_B, "b_second");

    // ld during KEXP is dropped
    kld = 1'b1; key = K_C1;
    tick();
    kld = 1'b0;
    tick(); tick();
    ld = 1'b1; text_in = CT_B;
    tick();
    ld = 1'b0;
    wait_key("kexp_ld_key_lat", 4);
    // ld during DEC is dropped and the in-flight result is unchanged
    ld = 1'b1; text_in = CT_C1;
    tick();
    ld = 1'b0;
    tick(); tick(); tick();
    ld = 1'b1; text_in = CT_B;
    tick();
    ld = 1'b0;
    wait_done("dec_ld", 5, PT_C1);
    tick();
    d0 = done_cnt;
    repeat (15) tick();
    chk("no_extra_done", 128'(done_cnt - d0), 128'(0));

    // kld and ld together: kld wins
    kld = 1'b1; key = K_B; ld = 1'b1; text_in = CT_C1;
    tick();
    kld = 1'b0; ld = 1'b0;
    d0 = done_cnt;
    wait_key("simul_key_lat", 1);
    chk("simul_no_done", 128'(done_cnt - d0), 128'(0));
    run_dec(CT_B, PT_B, "simul_after");

    // Reset in cycle N+5 of a decryption
    ld = 1'b1; text_in = CT_B;
    tick();
    ld = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_text_out", text_out, 128'h0);
    chk("midrst_key_ready", 128'(key_ready), 128'(0));
    ld = 1'b1; text_in = CT_B;
    tick();
    ld = 1'b0;
    d0 = done_cnt;
    repeat (15) tick();
    chk("postrst_ld_dropped", 128'(done_cnt - d0), 128'(0));
    do_kld(K_C1, "recover_key_lat");
    run_dec(CT_C1, PT_C1, "recover");

    // Loopback with random key/plaintext pairs
    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = m_encrypt(rk, rp);
      do_kld(rk, "loop_key_lat");
      run_dec(rc, rp, "loop");
    end

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
